// File: rtl/vedic_mult_pipe.sv
// Three-stage quarter-split (Vedic) multiplier with valid/ready handshake.
// Handles unsigned or two's-complement operands per transaction; product is 2*WIDTH bits.
module vedic_mult_pipe #(
    parameter int WIDTH = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               busy
);
    localparam int H  = WIDTH / 2;
    localparam int PW = 2 * WIDTH;
    localparam int MW = PW + 1;
    localparam logic [MW-1:0] TOP_BIT = {1'b1, {PW{1'b0}}};

    // Magnitude is one bit wider than the operand so the most negative value stays exact.
    function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] x, input logic is_signed);
        logic signed [WIDTH:0] sx;
        sx = signed'({x[WIDTH-1] & is_signed, x});
        return (sx < 0) ? unsigned'(-sx) : unsigned'(sx);
    endfunction

    function automatic logic [MW-1:0] zext(input logic [WIDTH-1:0] x);
        return {{(MW-WIDTH){1'b0}}, x};
    endfunction

    function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] m, input logic neg);
        return neg ? ({PW{1'b0}} - m) : m;
    endfunction

    logic adv;
    logic vld_p1, vld_p2, vld_p3;

    logic [WIDTH:0]   mag_a, mag_b;
    logic [WIDTH-1:0] pp_ll, pp_lh, pp_hl, pp_hh;

    logic [WIDTH-1:0] pp_ll_p1, pp_lh_p1, pp_hl_p1, pp_hh_p1;
    logic [WIDTH-1:0] mlo_a_p1, mlo_b_p1;
    logic             msb_a_p1, msb_b_p1, neg_p1;

    logic [MW-1:0]    mid_s2, corr_s2;
    logic [MW-1:0]    mag_p2;
    logic             neg_p2;
    logic             unused_mag_msb;

    assign adv       = !vld_p3 || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_p3;
    assign busy      = vld_p1 || vld_p2 || vld_p3;

    assign mag_a = magnitude(in_a, in_signed);
    assign mag_b = magnitude(in_b, in_signed);

    assign pp_ll = {{H{1'b0}}, mag_a[H-1:0]}     * {{H{1'b0}}, mag_b[H-1:0]};
    assign pp_lh = {{H{1'b0}}, mag_a[H-1:0]}     * {{H{1'b0}}, mag_b[WIDTH-1:H]};
    assign pp_hl = {{H{1'b0}}, mag_a[WIDTH-1:H]} * {{H{1'b0}}, mag_b[H-1:0]};
    assign pp_hh = {{H{1'b0}}, mag_a[WIDTH-1:H]} * {{H{1'b0}}, mag_b[WIDTH-1:H]};

    // Stage 1 -> 2: weighted sum of the quarters, plus the terms contributed by magnitude bit WIDTH.
    assign mid_s2  = zext(pp_ll_p1)
                   + ((zext(pp_lh_p1) + zext(pp_hl_p1)) << H)
                   + (zext(pp_hh_p1) << WIDTH);
    assign corr_s2 = (msb_a_p1 ? (zext(mlo_b_p1) << WIDTH) : '0)
                   + (msb_b_p1 ? (zext(mlo_a_p1) << WIDTH) : '0)
                   + ((msb_a_p1 && msb_b_p1) ? TOP_BIT : '0);

    assign unused_mag_msb = mag_p2[PW];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            pp_ll_p1 <= '0;
            pp_lh_p1 <= '0;
            pp_hl_p1 <= '0;
            pp_hh_p1 <= '0;
            mlo_a_p1 <= '0;
            mlo_b_p1 <= '0;
            msb_a_p1 <= 1'b0;
            msb_b_p1 <= 1'b0;
            neg_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            mag_p2   <= '0;
            neg_p2   <= 1'b0;
            vld_p3   <= 1'b0;
            out_p    <= '0;
        end else if (adv) begin
            // Stage 1: capture partial products of the operand magnitudes
            vld_p1   <= in_valid;
            pp_ll_p1 <= pp_ll;
            pp_lh_p1 <= pp_lh;
            pp_hl_p1 <= pp_hl;
            pp_hh_p1 <= pp_hh;
            mlo_a_p1 <= mag_a[WIDTH-1:0];
            mlo_b_p1 <= mag_b[WIDTH-1:0];
            msb_a_p1 <= mag_a[WIDTH];
            msb_b_p1 <= mag_b[WIDTH];
            neg_p1   <= in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
            // Stage 2: full-width product magnitude
            vld_p2   <= vld_p1;
            mag_p2   <= mid_s2 + corr_s2;
            neg_p2   <= neg_p1;
            // Stage 3: restore sign
            vld_p3   <= vld_p2;
            out_p    <= apply_sign(mag_p2[PW-1:0], neg_p2);
        end
    end
endmodule
